// File: rtl/svf_seq.sv
// svf_seq: time-multiplexed state-variable filter. One sample is processed
// per accepted request through a single shared 18 x SW signed multiplier,
// sequenced by a five-state FSM (IDLE, MUL_Q, MUL_FH, MUL_FB, OUT).
module svf_seq #(
  parameter int DATA_W = 12,
  parameter int GUARD  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  input  logic [17:0]       f_coef,
  input  logic [17:0]       q1_coef,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] sample_out,
  output logic              out_valid,
  output logic              busy,
  output logic              dropped
);

  localparam int SW = DATA_W + GUARD;  // internal state width
  localparam int CW = 18;              // coefficient width (Q2.16)
  localparam int PW = CW + SW;         // full-precision product width
  localparam int AW = SW + 4;          // accumulation width before saturation

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_Q,
    S_MUL_FH,
    S_MUL_FB,
    S_OUT
  } state_t;

  state_t state_q, state_d;

  logic signed [SW-1:0]     x_q, x_d;
  logic signed [CW-1:0]     f_q, f_d;
  logic signed [CW-1:0]     q1_q, q1_d;
  logic [1:0]               mode_q, mode_d;
  logic signed [SW-1:0]     low_q, low_d;
  logic signed [SW-1:0]     band_q, band_d;
  logic signed [SW-1:0]     high_q, high_d;
  logic signed [DATA_W-1:0] sample_out_q, sample_out_d;
  logic                     out_valid_q, out_valid_d;
  logic                     dropped_q, dropped_d;

  logic signed [CW-1:0] mul_a;
  logic signed [SW-1:0] mul_b;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] term;
  logic signed [SW-1:0] notch;
  logic signed [SW-1:0] sel;

  function automatic logic signed [AW-1:0] ext(input logic signed [SW-1:0] v);
    return {{(AW-SW){v[SW-1]}}, v};
  endfunction

  function automatic logic signed [SW-1:0] sat_sw(input logic signed [AW-1:0] v);
    if (v[AW-1:SW-1] == '0 || v[AW-1:SW-1] == '1) return v[SW-1:0];
    else if (v[AW-1])                              return {1'b1, {(SW-1){1'b0}}};
    else                                           return {1'b0, {(SW-1){1'b1}}};
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_dw(input logic signed [SW-1:0] v);
    if (v[SW-1:DATA_W-1] == '0 || v[SW-1:DATA_W-1] == '1) return v[DATA_W-1:0];
    else if (v[SW-1])                                     return {1'b1, {(DATA_W-1){1'b0}}};
    else                                                  return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  // Operand mux feeding the single shared multiplier.
  always_comb begin
    mul_a = f_q;
    mul_b = high_q;
    unique case (state_q)
      S_MUL_Q:  begin mul_a = q1_q; mul_b = band_q; end
      S_MUL_FH: begin mul_a = f_q;  mul_b = high_q; end
      S_MUL_FB: begin mul_a = f_q;  mul_b = band_q; end
      default:  begin mul_a = f_q;  mul_b = high_q; end
    endcase
  end

  // Shared multiplier, scaled back from Q2.16 with floor truncation.
  always_comb begin
    prod = mul_a * mul_b;
    term = AW'(prod >>> 16);
  end

  // Output selection for the OUT state.
  always_comb begin
    notch = sat_sw(ext(high_q) + ext(low_q));
    unique case (mode_q)
      2'b00:   sel = low_q;
      2'b01:   sel = band_q;
      2'b10:   sel = high_q;
      default: sel = notch;
    endcase
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    f_d          = f_q;
    q1_d         = q1_q;
    mode_d       = mode_q;
    low_d        = low_q;
    band_d       = band_q;
    high_d       = high_q;
    sample_out_d = sample_out_q;
    out_valid_d  = 1'b0;
    dropped_d    = sample_valid && (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (sample_valid) begin
          x_d     = {{GUARD{sample_in[DATA_W-1]}}, sample_in};
          f_d     = f_coef;
          q1_d    = q1_coef;
          mode_d  = mode;
          state_d = S_MUL_Q;
        end
      end
      S_MUL_Q: begin
        high_d  = sat_sw(ext(x_q) - ext(low_q) - term);
        state_d = S_MUL_FH;
      end
      S_MUL_FH: begin
        band_d  = sat_sw(ext(band_q) + term);
        state_d = S_MUL_FB;
      end
      S_MUL_FB: begin
        low_d   = sat_sw(ext(low_q) + term);
        state_d = S_OUT;
      end
      S_OUT: begin
        sample_out_d = sat_dw(sel);
        out_valid_d  = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      f_q          <= '0;
      q1_q         <= '0;
      mode_q       <= '0;
      low_q        <= '0;
      band_q       <= '0;
      high_q       <= '0;
      sample_out_q <= '0;
      out_valid_q  <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      f_q          <= f_d;
      q1_q         <= q1_d;
      mode_q       <= mode_d;
      low_q        <= low_d;
      band_q       <= band_d;
      high_q       <= high_d;
      sample_out_q <= sample_out_d;
      out_valid_q  <= out_valid_d;
      dropped_q    <= dropped_d;
    end
  end

  assign sample_out = sample_out_q;
  assign out_valid  = out_valid_q;
  assign dropped    = dropped_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_svf_seq.sv
// Scoreboard bench for svf_seq: directed scenarios plus randomized traffic,
// checked against a behavioural filter model kept in the bench.
module tb_svf_seq;

  localparam int DATA_W = 12;
  localparam int GUARD  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sample_valid = 1'b0;
  logic [DATA_W-1:0] sample_in = '0;
  logic [17:0]       f_coef = '0;
  logic [17:0]       q1_coef = '0;
  logic [1:0]        mode = '0;
  logic [DATA_W-1:0] sample_out;
  logic              out_valid;
  logic              busy;
  logic              dropped;

  svf_seq #(.DATA_W(DATA_W), .GUARD(GUARD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .f_coef       (f_coef),
    .q1_coef      (q1_coef),
    .mode         (mode),
    .sample_out   (sample_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .dropped      (dropped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int exp_drops = 0;
  int act_drops = 0;
  int last_acc = -100;

  // Reference filter state.
  longint m_low, m_band, m_high;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input int n);
    longint hi, lo;
    hi = (longint'(1) << (n - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int model_step(input int x, input int f, input int q1, input int m);
    longint o;
    m_high = sat(longint'(x) - m_low - ((longint'(q1) * m_band) >>> 16), 16);
    m_band = sat(m_band + ((longint'(f) * m_high) >>> 16), 16);
    m_low  = sat(m_low  + ((longint'(f) * m_band) >>> 16), 16);
    case (m)
      0:       o = m_low;
      1:       o = m_band;
      2:       o = m_high;
      default: o = sat(m_high + m_low, 16);
    endcase
    return int'(sat(o, 12));
  endfunction

  // Monitor: every out_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && dropped) act_drops++;
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("sample_out", longint'($signed(sample_out)), e.val);
        check("latency", cyc, e.cyc + 4);
      end
    end
  end

  // Asynchronous reset pulse; called at a negedge, returns at a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_sample_out", longint'($signed(sample_out)), 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_dropped", dropped, 0);
    sb.delete();
    m_low = 0; m_band = 0; m_high = 0;
    last_acc = -100;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents one request for a single cycle, then scrambles the inputs so
  // that any failure to latch at accept shows up as a wrong result.
  task automatic drive(input int x, input int f, input int q1, input int m);
    exp_t e;
    int ce;
    sample_in    = x[DATA_W-1:0];
    f_coef       = f[17:0];
    q1_coef      = q1[17:0];
    mode         = m[1:0];
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    sample_in    = DATA_W'($urandom);
    f_coef       = 18'($urandom);
    q1_coef      = 18'($urandom);
    mode         = 2'($urandom);
    ce = cyc;
    if (ce - last_acc >= 5) begin
      e.val = model_step(x, f, q1, m);
      e.cyc = ce;
      sb.push_back(e);
      last_acc = ce;
      check("busy_after_accept", busy, 1);
      check("no_drop_on_accept", dropped, 0);
    end else begin
      exp_drops++;
      check("dropped_pulse", dropped, 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int gap, x, f, q1, m;
    @(negedge clk);
    do_reset();

    // Integrator behaviour with f=1.0, q1=0, low-pass.
    drive(100, 65536, 0, 0); idle(5);
    drive(100, 65536, 0, 0); idle(6);

    // f=0 high-pass passes the input straight through; low-pass stays 0.
    do_reset();
    drive(500, 0, 0, 2); idle(4);
    drive(-300, 0, 0, 2); idle(4);
    drive(700, 0, 0, 0); idle(6);

    // Saturation: repeated full-scale input must clamp, never wrap.
    do_reset();
    for (int i = 0; i < 25; i++) begin
      drive(2047, 65536, 0, 0); idle(4);
    end
    idle(4);

    // Drop: second request two cycles later, then an accept at +5.
    do_reset();
    drive(100, 65536, 0, 0); idle(1);
    drive(999, 65536, 0, 0); idle(2);
    drive(50, 65536, 0, 0);
    drive(77, 65536, 0, 1); idle(2);
    drive(66, 65536, 0, 1); idle(6);

    // Reset during MUL_FH aborts the sample and clears filter state.
    drive(300, 65536, 0, 0);
    @(negedge clk);
    do_reset();
    idle(6);
    drive(100, 65536, 0, 0); idle(6);

    // Mode latched at accept: BP result despite HP on the next cycle.
    do_reset();
    drive(100, 65536, 0, 1);
    mode = 2'b10;
    idle(6);

    // Randomized traffic with random gaps, including back-to-back requests.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      x  = int'($urandom_range(0, 4095)) - 2048;
      f  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 262143)) - 131072
                                        : int'($urandom_range(0, 40000));
      q1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 262143)) - 131072
                                        : int'($urandom_range(0, 131071));
      m  = int'($urandom_range(0, 3));
      drive(x, f, q1, m);
      gap = int'($urandom_range(0, 6));
      idle(gap);
    end

    idle(10);
    check("scoreboard_empty", sb.size(), 0);
    check("drop_count", act_drops, exp_drops);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
